fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one FIFO write port between NUM_REQ packet sources in the write clock domain. Grants one source at a time and holds the grant until that source's packet ends or a burst limit is reached. Throttles on the FIFO's write-side fill count so the FIFO never sees a write when full. Drives fifo_wr_en/fifo_din directly into the async FIFO's write port.

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ packet sources.
// Grant is held until packet end or burst limit; ready throttles on the FIFO fill count.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned HEADROOM   = 16,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic                      fifo_wr_full,
    input  logic [CNT_W-1:0]          fifo_wr_data_count,
    output logic                      busy,
    output logic                      overflow_err
);

    localparam int unsigned OWN_W  = $clog2(NUM_REQ);
    localparam int unsigned BC_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned THRESH = FIFO_DEPTH - HEADROOM;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [OWN_W-1:0]    last_owner, last_owner_n;
    logic [BC_W-1:0]     beat_cnt, beat_cnt_n;
    logic [NUM_REQ-1:0]  grant_n;
    logic                wr_en_n;
    logic [DATA_W-1:0]   din_n;
    logic                overflow_n;

    logic                space_ok;
    logic                xfer;
    logic                pick_found;
    logic [OWN_W-1:0]    pick;
    logic [DATA_W-1:0]   sel_data;
    int unsigned         idx;

    // Headroom absorbs the write-side count latency so the FIFO never fills under us
    assign space_ok  = !fifo_wr_full && (fifo_wr_data_count < CNT_W'(THRESH));
    assign xfer      = (state == BURST) && space_ok && req_valid[last_owner];
    assign req_ready = ((state == BURST) && space_ok) ? grant : '0;
    assign busy      = (state == BURST);

    // First valid source searching upward from last_owner+1 with wrap
    always_comb begin
        pick       = last_owner;
        pick_found = 1'b0;
        idx        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last_owner) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req_valid[OWN_W'(idx)]) begin
                pick_found = 1'b1;
                pick       = OWN_W'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (OWN_W'(i) == last_owner) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n      = state;
        last_owner_n = last_owner;
        beat_cnt_n   = beat_cnt;
        grant_n      = grant;
        wr_en_n      = 1'b0;
        din_n        = fifo_din;
        overflow_n   = overflow_err | (fifo_wr_en & fifo_wr_full);

        case (state)
            IDLE: begin
                if (pick_found && space_ok) begin
                    state_n      = BURST;
                    grant_n      = NUM_REQ'(1) << pick;
                    last_owner_n = pick;
                    beat_cnt_n   = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    wr_en_n    = 1'b1;
                    din_n      = sel_data;
                    beat_cnt_n = beat_cnt + BC_W'(1);
                    // Burst-limit exit releases the port mid-packet; the source resumes later
                    if (req_last[last_owner] || (beat_cnt == BC_W'(MAX_BURST - 1))) begin
                        state_n    = IDLE;
                        grant_n    = '0;
                        beat_cnt_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_owner   <= OWN_W'(NUM_REQ - 1);
            beat_cnt     <= '0;
            grant        <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= '0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_n;
            last_owner   <= last_owner_n;
            beat_cnt     <= beat_cnt_n;
            grant        <= grant_n;
            fifo_wr_en   <= wr_en_n;
            fifo_din     <= din_n;
            overflow_err <= overflow_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: table of single-word arbitration vectors plus
// packet-level sequences driven from per-source word queues.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 11;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic              fifo_wr_full;
    logic [CW-1:0]     fifo_wr_data_count;
    logic              busy;
    logic              overflow_err;

    fifo_wr_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW),
        .FIFO_DEPTH(1024), .HEADROOM(16), .MAX_BURST(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .fifo_wr_full(fifo_wr_full), .fifo_wr_data_count(fifo_wr_data_count),
        .busy(busy), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Source-side word queues and sink-side log
    logic [31:0]   src_mem [NR][128];
    logic          src_lst [NR][128];
    int            head [NR];
    int            tail [NR];
    logic [NR-1:0] src_en;
    logic [31:0]   got   [512];
    int            got_n;
    logic [31:0]   exp_w [512];
    int            exp_n;
    logic [NR-1:0] glog  [32];
    int            gn;
    logic [NR-1:0] prev_grant;
    int            cyc, first_wr, last_wr;

    typedef struct packed {
        logic [NR-1:0] valid;
        logic [CW-1:0] cnt;
        logic          full;
        logic [NR-1:0] exp_grant;
    } vec_t;
    vec_t vt [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int src, input int pkt, input int beat);
        return {8'(src), 8'(pkt), 16'(beat)};
    endfunction

    function automatic logic [31:0] dword(input int src, input int v);
        return {8'hD0, 8'(v), 8'(src), 8'h5A};
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] oh);
        int r = 0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (head[i] < tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        src_en = '1; got_n = 0; exp_n = 0; gn = 0; prev_grant = '0;
        cyc = 0; first_wr = -1; last_wr = -1;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_wr_full = 1'b0; fifo_wr_data_count = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_packet(input int src, input int pkt, input int len, input int first_beat);
        for (int b = 0; b < len; b++) begin
            src_mem[src][tail[src]] = wd(src, pkt, first_beat + b);
            src_lst[src][tail[src]] = (b == len - 1);
            tail[src]++;
        end
    endtask

    task automatic push_exp(input int src, input int pkt, input int b0, input int n);
        for (int b = 0; b < n; b++) begin
            exp_w[exp_n] = wd(src, pkt, b0 + b);
            exp_n++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_en[i] && head[i] < tail[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_mem[i][head[i]];
                req_last[i]           = src_lst[i][head[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    // One clock: record handshakes before the edge, update queues/log after it
    task automatic cycle();
        logic [NR-1:0] x;
        #1;
        x = req_valid & req_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) if (x[i]) head[i]++;
        if (fifo_wr_en) begin
            if (got_n < 512) got[got_n] = fifo_din;
            got_n++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (grant != '0 && prev_grant == '0 && gn < 32) begin
            glog[gn] = grant;
            gn++;
        end
        prev_grant = grant;
        drive();
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        while ((pending() || busy || fifo_wr_en) && n < max_cyc) begin
            cycle();
            n++;
        end
        check({name, "_timeout"}, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic check_words(input string name);
        check({name, "_count"}, 32'(got_n), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_n && i < 512; i++)
            check($sformatf("%s_word%0d", name, i), got[i], exp_w[i]);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;

        // single-word arbitration vectors; last_owner after reset is 3
        vt[0]  = '{4'b1111, 11'd0,    1'b0, 4'b0001};
        vt[1]  = '{4'b1111, 11'd0,    1'b0, 4'b0010};
        vt[2]  = '{4'b0001, 11'd0,    1'b0, 4'b0001};
        vt[3]  = '{4'b1001, 11'd0,    1'b0, 4'b1000};
        vt[4]  = '{4'b1001, 11'd0,    1'b0, 4'b0001};
        vt[5]  = '{4'b0110, 11'd1008, 1'b0, 4'b0000};
        vt[6]  = '{4'b0110, 11'd1007, 1'b0, 4'b0010};
        vt[7]  = '{4'b1111, 11'd0,    1'b1, 4'b0000};
        vt[8]  = '{4'b0100, 11'd1024, 1'b0, 4'b0000};
        vt[9]  = '{4'b0011, 11'd5,    1'b0, 4'b0001};
        vt[10] = '{4'b0001, 11'd0,    1'b0, 4'b0001};
        vt[11] = '{4'b1110, 11'd0,    1'b0, 4'b0010};

        // Reset with all sources requesting
        clear_model();
        rst_n = 1'b0;
        req_valid = '1;
        req_last  = '1;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dword(i, 99);
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_din", fifo_din, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_grant", 32'(grant), 32'b0001);
        check("rel_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("rel_wr_en", 32'(fifo_wr_en), 32'd1);
        check("rel_din", fifo_din, dword(0, 99));
        req_valid = '0;
        @(posedge clk);
        #1;

        // Table-driven arbitration and throttle vectors
        clear_model();
        do_reset();
        for (int v = 0; v < 12; v++) begin
            req_valid = vt[v].valid;
            req_last  = '1;
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dword(i, v);
            fifo_wr_data_count = vt[v].cnt;
            fifo_wr_full       = vt[v].full;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vt[v].exp_grant));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(|vt[v].exp_grant));
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vt[v].exp_grant));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_wr_en", v), 32'(fifo_wr_en), 32'(|vt[v].exp_grant));
            if (vt[v].exp_grant != '0)
                check($sformatf("vec%0d_din", v), fifo_din, dword(oh2idx(vt[v].exp_grant), v));
            check($sformatf("vec%0d_grant_clr", v), 32'(grant), 32'd0);
            req_valid = '0;
            fifo_wr_full = 1'b0;
            fifo_wr_data_count = '0;
            @(posedge clk);
            #1;
        end
        check("vec_ovf", 32'(overflow_err), 32'd0);

        // Round robin: two 3-word packets per source
        clear_model();
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NR; s++) begin
                load_packet(s, p, 3, 0);
                push_exp(s, p, 0, 3);
            end
        drive();
        drain(200, "rr");
        check_words("rr");
        check("rr_grants", 32'(gn), 32'd8);
        for (int g = 0; g < 8 && g < gn; g++)
            check($sformatf("rr_grant%0d", g), 32'(glog[g]), 32'(4'b0001 << (g % 4)));
        check("rr_span", 32'(last_wr - first_wr + 1), 32'd31);

        // Burst limit: 100-word packet on source 2, 5-word packet on source 3
        clear_model();
        do_reset();
        load_packet(2, 0, 100, 0);
        load_packet(3, 0, 5, 0);
        push_exp(2, 0, 0, 64);
        push_exp(3, 0, 0, 5);
        push_exp(2, 0, 64, 36);
        drive();
        drain(400, "bl");
        check_words("bl");
        check("bl_grants", 32'(gn), 32'd3);
        if (gn >= 3) begin
            check("bl_grant0", 32'(glog[0]), 32'b0100);
            check("bl_grant1", 32'(glog[1]), 32'b1000);
            check("bl_grant2", 32'(glog[2]), 32'b0100);
        end

        // Throttle on the fill count threshold (1008)
        clear_model();
        fifo_wr_data_count = 11'd1007;
        do_reset();
        load_packet(1, 0, 40, 0);
        push_exp(1, 0, 0, 40);
        drive();
        n = 0;
        while (grant != 4'b0010 && n < 20) begin
            cycle();
            n++;
        end
        check("thr_grant", 32'(grant), 32'b0010);
        repeat (3) cycle();
        #1;
        check("thr_ready_1007", 32'(req_ready), 32'b0010);
        fifo_wr_data_count = 11'd1008;
        #1;
        check("thr_ready_1008", 32'(req_ready), 32'd0);
        cycle();
        check("thr_wr_stop", 32'(fifo_wr_en), 32'd0);
        repeat (3) begin
            cycle();
            check("thr_hold_wr", 32'(fifo_wr_en), 32'd0);
            check("thr_hold_grant", 32'(grant), 32'b0010);
        end
        fifo_wr_data_count = 11'd1000;
        #1;
        check("thr_ready_1000", 32'(req_ready), 32'b0010);
        cycle();
        check("thr_resume", 32'(fifo_wr_en), 32'd1);
        drain(200, "thr");
        check_words("thr");

        // Owner stall and FIFO full with grant held
        clear_model();
        do_reset();
        load_packet(0, 0, 10, 0);
        push_exp(0, 0, 0, 10);
        drive();
        n = 0;
        while (got_n < 3 && n < 20) begin
            cycle();
            n++;
        end
        src_en[0] = 1'b0;
        drive();
        repeat (5) begin
            cycle();
            check("stall_wr", 32'(fifo_wr_en), 32'd0);
            check("stall_grant", 32'(grant), 32'b0001);
        end
        src_en[0] = 1'b1;
        fifo_wr_full = 1'b1;
        drive();
        repeat (3) begin
            cycle();
            check("full_wr", 32'(fifo_wr_en), 32'd0);
            check("full_ovf", 32'(overflow_err), 32'd0);
        end
        fifo_wr_full = 1'b0;
        drain(100, "stall");
        check_words("stall");
        check("stall_ovf", 32'(overflow_err), 32'd0);

        // Overflow: FIFO reports full while a write is on the port
        clear_model();
        do_reset();
        load_packet(0, 0, 4, 0);
        drive();
        n = 0;
        while (!fifo_wr_en && n < 20) begin
            cycle();
            n++;
        end
        check("ovf_pre", 32'(overflow_err), 32'd0);
        fifo_wr_full = 1'b1;
        cycle();
        check("ovf_set", 32'(overflow_err), 32'd1);
        fifo_wr_full = 1'b0;
        repeat (3) cycle();
        check("ovf_sticky", 32'(overflow_err), 32'd1);
        drain(100, "ovf");
        check("ovf_sticky_end", 32'(overflow_err), 32'd1);
        req_valid = '0;
        do_reset();
        check("ovf_reset", 32'(overflow_err), 32'd0);

        // Reset on beat 10 of a 20-word packet
        clear_model();
        do_reset();
        load_packet(0, 0, 20, 0);
        load_packet(1, 0, 5, 0);
        drive();
        n = 0;
        while (head[0] < 10 && n < 40) begin
            cycle();
            n++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mr_wr", 32'(fifo_wr_en), 32'd0);
        check("mr_grant", 32'(grant), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_din", fifo_din, 32'd0);
        check("mr_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_grant = '0;
        cycle();
        check("mr_regrant", 32'(grant), 32'b0001);
        drain(100, "mr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
